xnor_accum: RTL and testbench
=============================

XNOR_ACCUM -- requirements
Module: xnor_accum

Interface
REQ-001 SHALL have parameter N_IN, default 784: binary products per neuron.
REQ-002 SHALL have parameter N_OUT, default 1024: neurons per layer.
REQ-003 SHALL have parameter ACC_W, default 12: signed accumulator width; legal only when 2^(ACC_W-1)-1 >= N_IN.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that begins a layer; sampled only in IDLE.
REQ-007 SHALL have port in_valid, input, 1: w_bit and x_bit are valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: high only in ACCUM.
REQ-009 SHALL have port w_bit, input, 1: weight bit (1 = +1, 0 = -1).
REQ-010 SHALL have port x_bit, input, 1: activation bit (1 = +1, 0 = -1).
REQ-011 SHALL have port out_valid, output, 1: neuron result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port out_bit, output, 1: sign activation of the neuron.
REQ-014 SHALL have port out_sum, output, ACC_W: signed pre-activation sum.
REQ-015 SHALL have port layer_done, output, 1: one-cycle pulse after the last neuron is accepted.

Function
REQ-016 SHALL implement states IDLE, ACCUM, EMIT, DONE.
REQ-017 IDLE->ACCUM on start; the accumulator and element counter clear on this transition.
REQ-018 ACCUM: each in_valid&&in_ready beat adds +1 to acc when w_bit==x_bit and -1 otherwise; the element counter increments.
REQ-019 The beat with element count == N_IN-1 SHALL move to EMIT the next cycle, with the final sum registered into out_sum: one-cycle latency from the last beat to out_valid.
REQ-020 EMIT: out_valid=1; out_sum and out_bit SHALL be held stable until out_ready.
REQ-021 out_bit = 1 when the biased sum >= 0, else 0; zero maps to 1.
REQ-022 EMIT with out_ready: if neuron count == N_OUT-1, go to DONE; otherwise go to ACCUM with acc, element counter and out_valid cleared and the neuron counter incremented.
REQ-023 DONE: layer_done=1 for exactly one cycle, then IDLE.
REQ-024 The accumulator SHALL saturate at +/-(2^(ACC_W-1)-1) and never wrap.
REQ-025 in_valid outside ACCUM SHALL be ignored; no beat is consumed.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 When the last beat of a neuron arrives, that same cycle SHALL accept no further beat; in_ready drops in EMIT.

Reset
REQ-028 While rst==0 at a clock edge: state=IDLE, acc=0, all counters 0, in_ready=0, out_valid=0, out_bit=0, out_sum=0, layer_done=0.
REQ-029 Reset asserted mid-layer SHALL abort the layer; no out_valid and no layer_done are produced afterwards without a new start.

Configuration
REQ-030 Macro XNOR_ACCUM_BIAS_EN defined: add input port bias, ACC_W signed, sampled at each EMIT entry; out_bit = (acc + bias >= 0), with the addition saturated; out_sum SHALL remain the raw acc.
REQ-031 Macro XNOR_ACCUM_BIAS_EN undefined: no bias port; out_bit = (acc >= 0).

Structure
REQ-032 Shared package bnn_pkg SHALL hold the state encoding, N_IN_DEFAULT=784, N_OUT_DEFAULT=1024 and ACC_W_DEFAULT=12.
REQ-033 One sub-module, xnor_sat_acc (XNOR +/-1 step with saturating signed add), SHALL be instantiated once.

Verification
REQ-034 Match case: N_IN=4, N_OUT=1, 4 beats all w=x=1 -> out_sum=4, out_bit=1, out_valid one cycle after the 4th beat, layer_done follows the out_ready handshake.
REQ-035 Mismatch and tie cases: N_IN=4, all w=1 with x=0 -> out_sum=-4, out_bit=0; then 2 matches and 2 mismatches -> out_sum=0, out_bit=1.
REQ-036 Backpressure: out_ready held low 5 cycles in EMIT -> out_valid, out_sum and out_bit stable; in_ready=0; in_valid beats ignored.
REQ-037 Reset mid-neuron: rst=0 after the 2nd of 4 beats -> all outputs 0; a new start with 4 matches -> out_sum=4 (no residue).
REQ-038 Saturation: ACC_W=3, N_IN=5, all matches -> out_sum=3, no wrap.
REQ-039 Bias (XNOR_ACCUM_BIAS_EN): N_IN=4, sum=-2, bias=3 -> out_bit=1, out_sum=-2; with bias=1 -> out_bit=0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary neural network datapath blocks:
// layer-sequencing state encoding and the default layer geometry.
package bnn_pkg;

    // Layer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int N_IN_DEFAULT  = 784;
    localparam int N_OUT_DEFAULT = 1024;
    localparam int ACC_W_DEFAULT = 12;

endpackage

// File: rtl/xnor_accum_sat.sv
// xnor_sat_acc: one binary-product step. XNOR of weight and activation
// selects +1 (equal bits) or -1 (different bits); the signed add clamps at
// +/-(2^(ACC_W-1)-1) so the running sum never wraps.
module xnor_sat_acc #(
    parameter int ACC_W = 12
) (
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic                    w_bit,
    input  logic                    x_bit,
    output logic signed [ACC_W-1:0] acc_out
);

    // Symmetric limits: the most negative code is never produced
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};

    // Step up on a match, down on a mismatch, holding at the limits
    always_comb begin
        acc_out = acc_in;
        if (w_bit == x_bit) begin
            if (acc_in < ACC_MAX) begin
                acc_out = acc_in + ONE;
            end
        end else begin
            if (acc_in > ACC_MIN) begin
                acc_out = acc_in - ONE;
            end
        end
    end

endmodule

// File: rtl/xnor_accum.sv
// xnor_accum: binarised neuron layer engine. Streams N_IN weight/activation
// bit pairs per neuron, accumulates the +/-1 XNOR products, and emits the
// pre-activation sum with its sign bit for each of N_OUT neurons.
//
// Optional feature macro: XNOR_ACCUM_BIAS_EN adds a signed bias input that
// shifts the sign decision (out_sum stays the raw accumulation).
//
// Handshakes: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. A
// producer holds its data stable while valid is high and ready is low.
module xnor_accum
    import bnn_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int N_OUT = N_OUT_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    w_bit,
    input  logic                    x_bit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    layer_done,
`ifdef XNOR_ACCUM_BIAS_EN
    input  logic signed [ACC_W-1:0] bias,
`endif
    output state_t                  dbg_state
);

    localparam int EW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [EW-1:0] LAST_E = EW'(N_IN - 1);
    localparam logic [NW-1:0] LAST_N = NW'(N_OUT - 1);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic [EW-1:0]           elem_cnt;
    logic [NW-1:0]           neuron_cnt;
    logic                    act_bit;

    assign dbg_state = state;

    xnor_sat_acc #(
        .ACC_W (ACC_W)
    ) u_step (
        .acc_in  (acc),
        .w_bit   (w_bit),
        .x_bit   (x_bit),
        .acc_out (acc_next)
    );

`ifdef XNOR_ACCUM_BIAS_EN
    localparam logic signed [ACC_W:0] WIDE_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] WIDE_MIN = -WIDE_MAX;

    logic signed [ACC_W:0]   biased_wide;
    logic signed [ACC_W-1:0] biased_sat;

    // Sign of the bias-shifted final sum, with the addition clamped to range
    always_comb begin
        biased_wide = $signed({acc_next[ACC_W-1], acc_next})
                    + $signed({bias[ACC_W-1], bias});
        biased_sat  = biased_wide[ACC_W-1:0];
        if (biased_wide > WIDE_MAX) begin
            biased_sat = WIDE_MAX[ACC_W-1:0];
        end else if (biased_wide < WIDE_MIN) begin
            biased_sat = WIDE_MIN[ACC_W-1:0];
        end
        act_bit = ~biased_sat[ACC_W-1];
    end
`else
    // Sign of the final sum; zero counts as non-negative
    always_comb begin
        act_bit = ~acc_next[ACC_W-1];
    end
`endif

    // Layer sequencer with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            elem_cnt   <= '0;
            neuron_cnt <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            out_sum    <= '0;
            layer_done <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_ACCUM;
                        acc        <= '0;
                        elem_cnt   <= '0;
                        neuron_cnt <= '0;
                        in_ready   <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= acc_next;
                        if (elem_cnt == LAST_E) begin
                            // Last beat: close the input side this edge
                            state     <= ST_EMIT;
                            elem_cnt  <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next;
                            out_bit   <= act_bit;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (neuron_cnt == LAST_N) begin
                            state      <= ST_DONE;
                            layer_done <= 1'b1;
                        end else begin
                            state      <= ST_ACCUM;
                            acc        <= '0;
                            elem_cnt   <= '0;
                            neuron_cnt <= neuron_cnt + 1'b1;
                            in_ready   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    neuron_cnt <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_accum.sv
// Bench for xnor_accum: three instances share one stimulus bus; the one
// selected by sel is observed. A: N_IN=4 N_OUT=1, B: N_IN=4 N_OUT=2,
// C: N_IN=5 N_OUT=1 ACC_W=3. Expected results go to exp_q when a neuron is
// driven and are popped when the observed instance emits a result.
module tb_xnor_accum;
  import bnn_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid, w_bit, x_bit, out_ready;
`ifdef XNOR_ACCUM_BIAS_EN
  logic signed [11:0] bias;
`endif

  logic in_ready_a, out_valid_a, out_bit_a, layer_done_a;
  logic signed [11:0] out_sum_a;
  state_t state_a;
  logic in_ready_b, out_valid_b, out_bit_b, layer_done_b;
  logic signed [11:0] out_sum_b;
  state_t state_b;
  logic in_ready_c, out_valid_c, out_bit_c, layer_done_c;
  logic signed [2:0] out_sum_c;
  state_t state_c;

  xnor_accum #(.N_IN(4), .N_OUT(1), .ACC_W(12)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_a), .w_bit(w_bit), .x_bit(x_bit),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_bit(out_bit_a),
    .out_sum(out_sum_a), .layer_done(layer_done_a),
`ifdef XNOR_ACCUM_BIAS_EN
    .bias(bias),
`endif
    .dbg_state(state_a)
  );

  xnor_accum #(.N_IN(4), .N_OUT(2), .ACC_W(12)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_b), .w_bit(w_bit), .x_bit(x_bit),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_bit(out_bit_b),
    .out_sum(out_sum_b), .layer_done(layer_done_b),
`ifdef XNOR_ACCUM_BIAS_EN
    .bias(bias),
`endif
    .dbg_state(state_b)
  );

  xnor_accum #(.N_IN(5), .N_OUT(1), .ACC_W(3)) dut_c (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_c), .w_bit(w_bit), .x_bit(x_bit),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_bit(out_bit_c),
    .out_sum(out_sum_c), .layer_done(layer_done_c),
`ifdef XNOR_ACCUM_BIAS_EN
    .bias(bias[2:0]),
`endif
    .dbg_state(state_c)
  );

  // ---------------- observed instance ----------------
  int sel = 0;
  logic obs_in_ready, obs_out_valid, obs_bit, obs_done;
  logic [11:0] obs_sum;
  state_t obs_state;

  always_comb begin
    case (sel)
      0: begin
        obs_in_ready = in_ready_a; obs_out_valid = out_valid_a; obs_bit = out_bit_a;
        obs_done = layer_done_a; obs_sum = out_sum_a; obs_state = state_a;
      end
      1: begin
        obs_in_ready = in_ready_b; obs_out_valid = out_valid_b; obs_bit = out_bit_b;
        obs_done = layer_done_b; obs_sum = out_sum_b; obs_state = state_b;
      end
      default: begin
        obs_in_ready = in_ready_c; obs_out_valid = out_valid_c; obs_bit = out_bit_c;
        obs_done = layer_done_c; obs_sum = {{9{out_sum_c[2]}}, out_sum_c}; obs_state = state_c;
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference neuron: {sign bit, raw sum} with clamped accumulation
  function automatic logic [12:0] model(input logic [7:0] w, input logic [7:0] x,
                                        input int n, input int acc_w, input int bias_v);
    int mx, acc, b;
    mx = (1 << (acc_w - 1)) - 1;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (w[i] == x[i]) begin
        if (acc < mx) acc++;
      end else begin
        if (acc > -mx) acc--;
      end
    end
    b = acc + bias_v;
    if (b > mx) b = mx;
    if (b < -mx) b = -mx;
    model = {(b >= 0) ? 1'b1 : 1'b0, 12'(acc)};
  endfunction

  function automatic int cur_bias();
`ifdef XNOR_ACCUM_BIAS_EN
    cur_bias = int'(bias);
`else
    cur_bias = 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    w_bit = 1'b0; x_bit = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic start_layer();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_accum", obs_in_ready, 1);
  endtask

  task automatic send_neuron(input logic [7:0] w, input logic [7:0] x, input int n, input bit push);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!obs_in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        check("in_ready_timeout", obs_in_ready, 1);
        break;
      end
      in_valid = 1'b1; w_bit = w[i]; x_bit = x[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (push) begin
      exp_q.push_back(model(w, x, n, (sel == 2) ? 3 : 12, cur_bias()));
      check("latency_valid", obs_out_valid, 1);
      check("emit_in_ready", obs_in_ready, 0);
    end
  endtask

  task automatic collect(input int hold);
    int t;
    logic [11:0] s0;
    logic b0;
    logic [12:0] e;
    t = 0;
    while (!obs_out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_wait", obs_out_valid, 1);
    s0 = obs_sum; b0 = obs_bit;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      w_bit = 1'($urandom_range(0, 1));
      x_bit = 1'($urandom_range(0, 1));
      start = (i == 0);
      @(negedge clk);
      check("hold_valid", obs_out_valid, 1);
      check("hold_sum", obs_sum, s0);
      check("hold_bit", obs_bit, b0);
      check("hold_in_ready", obs_in_ready, 0);
    end
    in_valid = 1'b0; start = 1'b0;
    check("sb_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_sum", obs_sum, e[11:0]);
      check("out_bit", obs_bit, e[12]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", obs_out_valid, 0);
  endtask

  task automatic check_layer_end();
    check("layer_done_hi", obs_done, 1);
    check("state_done", obs_state, ST_DONE);
    @(negedge clk);
    check("layer_done_lo", obs_done, 0);
    check("state_idle", obs_state, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wr, xr;
`ifdef XNOR_ACCUM_BIAS_EN
    bias = '0;
`endif
    sel = 0;
    do_reset();
    check("rst_in_ready", obs_in_ready, 0);
    check("rst_out_valid", obs_out_valid, 0);
    check("rst_out_sum", obs_sum, 0);
    check("rst_out_bit", obs_bit, 0);
    check("rst_layer_done", obs_done, 0);
    check("rst_state", obs_state, ST_IDLE);

    // beats offered in IDLE are ignored
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; w_bit = 1'b0; x_bit = 1'b1;
      @(negedge clk);
      check("idle_in_ready", obs_in_ready, 0);
    end
    in_valid = 1'b0;

    // all matches, with 5 cycles of backpressure
    start_layer();
    send_neuron(8'h0F, 8'h0F, 4, 1'b1);
    collect(5);
    check_layer_end();

    // reset after the 2nd beat aborts the layer
    start_layer();
    send_neuron(8'h0F, 8'h0F, 2, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_in_ready", obs_in_ready, 0);
    check("abort_out_valid", obs_out_valid, 0);
    check("abort_out_sum", obs_sum, 0);
    check("abort_out_bit", obs_bit, 0);
    check("abort_state", obs_state, ST_IDLE);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; w_bit = 1'b1; x_bit = 1'b1;
      @(negedge clk);
      check("abort_no_valid", obs_out_valid, 0);
      check("abort_no_done", obs_done, 0);
    end
    in_valid = 1'b0;
    start_layer();
    send_neuron(8'h0F, 8'h0F, 4, 1'b1);
    collect(0);
    check_layer_end();

    // two-neuron layer: all mismatches, then a tie
    sel = 1;
    do_reset();
    start_layer();
    send_neuron(8'h0F, 8'h00, 4, 1'b1);
    collect(2);
    check("mid_layer_done", obs_done, 0);
    check("next_in_ready", obs_in_ready, 1);
    send_neuron(8'h0F, 8'h05, 4, 1'b1);
    collect(0);
    check_layer_end();

    // random two-neuron layers
    for (int l = 0; l < 3; l++) begin
      start_layer();
      for (int k = 0; k < 2; k++) begin
        wr = $urandom_range(0, 15);
        xr = $urandom_range(0, 15);
        send_neuron(8'(wr), 8'(xr), 4, 1'b1);
        collect($urandom_range(0, 3));
      end
      check_layer_end();
    end

    // saturation at +3 with a 3-bit accumulator
    sel = 2;
    do_reset();
    start_layer();
    send_neuron(8'h1F, 8'h1F, 5, 1'b1);
    collect(0);
    check_layer_end();

`ifdef XNOR_ACCUM_BIAS_EN
    // bias shifts the sign only: sum -2 with bias 3, then bias 1
    sel = 0;
    do_reset();
    bias = 12'sd3;
    start_layer();
    send_neuron(8'h0F, 8'h01, 4, 1'b1);
    collect(0);
    check_layer_end();
    bias = 12'sd1;
    start_layer();
    send_neuron(8'h0F, 8'h01, 4, 1'b1);
    collect(0);
    check_layer_end();
    bias = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
